pipe_mem_wb_skid: RTL and testbench

Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer (output register plus skid register). It sits between the data-memory stage and the register-file write port. It carries the ALU result, load data, destination address and write-back controls. It also provides the final write-back mux, stage flush and a saturating back-pressure counter.

---
 rtl/pipe_mem_wb_skid.sv | 114 +++++++++++
 tb/tb_pipe_mem_wb_skid.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_wb_skid.sv
// MEM/WB pipeline stage with a two-entry skid buffer,
// final write-back mux and a back-pressure cycle counter.
module pipe_mem_wb_skid #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned CNT_W       = 16,
  parameter bit          ZERO_REG_WB = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_we_o,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_to_reg;
    logic              reg_write;
  } mem_wb_t;

  mem_wb_t          in_d;
  mem_wb_t          out_q;
  mem_wb_t          skid_q;
  logic             out_v_q;
  logic             skid_v_q;
  logic [CNT_W-1:0] bp_q;
  logic             accept;
  logic             consume;
  logic             rd_ok;

  assign in_d = '{
    alu_res:    alu_res_i,
    read_data:  read_data_i,
    rd_addr:    rd_addr_i,
    mem_to_reg: mem_to_reg_i,
    reg_write:  reg_write_i
  };

  // Ready depends only on skid occupancy, never on out_ready_i.
  assign in_ready_o = ~skid_v_q;
  assign accept     = in_valid_i & in_ready_o;
  assign consume    = out_v_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (flush_i) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (consume && skid_v_q) begin
      out_q <= skid_q;
      if (accept) begin
        skid_q <= in_d;
      end else begin
        skid_v_q <= 1'b0;
      end
    end else if (consume) begin
      out_v_q <= accept;
      if (accept) begin
        out_q <= in_d;
      end
    end else if (!out_v_q) begin
      if (accept) begin
        out_q   <= in_d;
        out_v_q <= 1'b1;
      end
    end else if (accept) begin
      skid_q   <= in_d;
      skid_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bp_q <= '0;
    end else if (out_v_q && !out_ready_i && (bp_q != {CNT_W{1'b1}})) begin
      bp_q <= bp_q + 1'b1;
    end
  end

  assign out_valid_o  = out_v_q;
  assign alu_res_o    = out_q.alu_res;
  assign read_data_o  = out_q.read_data;
  assign rd_addr_o    = out_q.rd_addr;
  assign mem_to_reg_o = out_q.mem_to_reg;
  assign reg_write_o  = out_q.reg_write;
  assign bp_cnt_o     = bp_q;

  assign rd_ok     = (out_q.rd_addr != '0) || !ZERO_REG_WB;
  assign wb_data_o = out_q.mem_to_reg ? out_q.read_data : out_q.alu_res;
  assign wb_we_o   = out_v_q & out_q.reg_write & rd_ok;

endmodule

// File: tb/tb_pipe_mem_wb_skid.sv
// Directed bench for pipe_mem_wb_skid: vector table
// plus hand sequences for write-back, saturation and reset.
module tb_pipe_mem_wb_skid;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] alu_res_i = '0;
  logic [DW-1:0] read_data_i = '0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          mem_to_reg_i = 1'b0;
  logic          reg_write_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] alu_res_o;
  logic [DW-1:0] read_data_o;
  logic [AW-1:0] rd_addr_o;
  logic          mem_to_reg_o;
  logic          reg_write_o;
  logic [DW-1:0] wb_data_o;
  logic          wb_we_o;
  logic [CW-1:0] bp_cnt_o;

  pipe_mem_wb_skid #(
    .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .ZERO_REG_WB(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_res_i(alu_res_i), .read_data_i(read_data_i),
    .rd_addr_i(rd_addr_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .alu_res_o(alu_res_o),
    .read_data_o(read_data_o), .rd_addr_o(rd_addr_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
    .bp_cnt_o(bp_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          vin;
    logic [DW-1:0] alu;
    logic          ordy;
    logic          fl;
    logic          e_v;
    logic [DW-1:0] e_alu;
    logic          e_ir;
    logic [CW-1:0] e_bp;
  } vec_t;

  vec_t vt[17];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a,
                       input logic [DW-1:0] rdat, input logic [AW-1:0] rd,
                       input logic m2r, input logic ordy);
    in_valid_i   = v;
    alu_res_i    = a;
    read_data_i  = rdat;
    rd_addr_i    = rd;
    mem_to_reg_i = m2r;
    reg_write_i  = 1'b1;
    out_ready_i  = ordy;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    flush_i = 1'b0;
    #12;
    rst_i = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(input logic vin, input logic [DW-1:0] alu,
                              input logic ordy, input logic fl,
                              input logic ev, input logic [DW-1:0] ea,
                              input logic eir, input logic [CW-1:0] ebp);
    vec_t r;
    r.vin = vin; r.alu = alu; r.ordy = ordy; r.fl = fl;
    r.e_v = ev; r.e_alu = ea; r.e_ir = eir; r.e_bp = ebp;
    return r;
  endfunction

  initial begin
    // stream, back-pressure fill/drain, full-skid consume, flush
    vt[0]  = mk(1, 32'h11, 1, 0, 1, 32'h11, 1, 0);
    vt[1]  = mk(1, 32'h22, 1, 0, 1, 32'h22, 1, 0);
    vt[2]  = mk(1, 32'h33, 1, 0, 1, 32'h33, 1, 0);
    vt[3]  = mk(0, 32'h00, 1, 0, 0, 32'h00, 1, 0);
    vt[4]  = mk(1, 32'hA0, 0, 0, 1, 32'hA0, 1, 0);
    vt[5]  = mk(1, 32'hA1, 0, 0, 1, 32'hA0, 0, 1);
    vt[6]  = mk(1, 32'hA2, 0, 0, 1, 32'hA0, 0, 2);
    vt[7]  = mk(1, 32'hA2, 0, 0, 1, 32'hA0, 0, 3);
    vt[8]  = mk(1, 32'hA2, 1, 0, 1, 32'hA1, 1, 3);
    vt[9]  = mk(1, 32'hA2, 1, 0, 1, 32'hA2, 1, 3);
    vt[10] = mk(0, 32'h00, 1, 0, 0, 32'h00, 1, 3);
    vt[11] = mk(1, 32'h01, 0, 0, 1, 32'h01, 1, 3);
    vt[12] = mk(1, 32'h02, 0, 0, 1, 32'h01, 0, 4);
    vt[13] = mk(1, 32'h03, 1, 0, 1, 32'h02, 1, 4);
    vt[14] = mk(1, 32'h03, 0, 0, 1, 32'h02, 0, 5);
    vt[15] = mk(1, 32'h55, 0, 1, 0, 32'h00, 1, 6);
    vt[16] = mk(0, 32'h00, 1, 0, 0, 32'h00, 1, 6);

    do_reset();
    chk("rst_out_valid", {31'b0, out_valid_o}, 0);
    chk("rst_in_ready", {31'b0, in_ready_o}, 1);
    chk("rst_alu", alu_res_o, 0);
    chk("rst_wb_we", {31'b0, wb_we_o}, 0);
    chk("rst_bp", {28'b0, bp_cnt_o}, 0);

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].vin, vt[i].alu, '0, 5'd3, 1'b0, vt[i].ordy);
      flush_i = vt[i].fl;
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid_o},
          {31'b0, vt[i].e_v});
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready_o},
          {31'b0, vt[i].e_ir});
      chk($sformatf("v%0d_bp", i), {28'b0, bp_cnt_o}, {28'b0, vt[i].e_bp});
      chk($sformatf("v%0d_wb_we", i), {31'b0, wb_we_o},
          {31'b0, vt[i].e_v});
      if (vt[i].e_v)
        chk($sformatf("v%0d_alu", i), alu_res_o, vt[i].e_alu);
    end
    flush_i = 1'b0;

    // write-back mux and rd==0 gating
    do_reset();
    drive(1, 32'hBEEF, 32'hDEAD, 5'd0, 1'b1, 1'b0);
    step();
    chk("wb_data_load", wb_data_o, 32'hDEAD);
    chk("wb_we_rd0", {31'b0, wb_we_o}, 0);
    chk("reg_write_o", {31'b0, reg_write_o}, 1);
    drive(1, 32'hBEEF, 32'hDEAD, 5'd7, 1'b1, 1'b1);
    step();
    chk("wb_we_rd7", {31'b0, wb_we_o}, 1);
    chk("rd_addr_o", {27'b0, rd_addr_o}, 7);
    drive(1, 32'hBEEF, 32'hDEAD, 5'd7, 1'b0, 1'b1);
    step();
    chk("wb_data_alu", wb_data_o, 32'hBEEF);
    chk("read_data_o", read_data_o, 32'hDEAD);

    // counter saturation, then async reset mid-stall
    do_reset();
    drive(1, 32'h77, '0, 5'd9, 1'b0, 1'b0);
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_bp", {28'b0, bp_cnt_o}, 15);
    chk("sat_alu_held", alu_res_o, 32'h77);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid_o}, 0);
    chk("arst_in_ready", {31'b0, in_ready_o}, 1);
    chk("arst_bp", {28'b0, bp_cnt_o}, 0);
    chk("arst_alu", alu_res_o, 0);
    chk("arst_rd", {27'b0, rd_addr_o}, 0);
    chk("arst_wb", wb_data_o, 0);
    #5;
    rst_i = 1'b1;
    step();
    chk("post_rst_valid", {31'b0, out_valid_o}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
